// File: rtl/avalon_reg_slave.sv
// Avalon-MM register-bank slave with a programmable number of wait states.
// One transaction is in flight at a time; read data returns one cycle after the accept.
module avalon_reg_slave #(
    parameter int AW   = 4,
    parameter int DW   = 4,
    parameter int WAIT = 3,
    parameter int CW   = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          read,
    input  logic          write,
    input  logic [AW-1:0] address,
    input  logic [DW-1:0] writedata,
    output logic          waitrequest,
    output logic          readdatavalid,
    output logic [DW-1:0] readdata,
    output logic [CW-1:0] wr_count,
    output logic [CW-1:0] rd_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITING = 2'd1,
        ACCEPT  = 2'd2
    } state_t;

    localparam int         DEPTH    = 1 << AW;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT - 1);

    state_t        state;
    state_t        state_nx;
    logic [3:0]    cnt;
    logic [3:0]    cnt_nx;
    logic          rw;
    logic          commit_wr;
    logic          commit_rd;
    logic [DW-1:0] bank [DEPTH];

    assign rw = read | write;

    // Write wins over read when both are held in the accept cycle.
    assign commit_wr = (state == ACCEPT) && write;
    assign commit_rd = (state == ACCEPT) && read && !write;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (rw) begin
                    state_nx = WAITING;
                    cnt_nx   = CNT_LOAD;
                end
            end
            WAITING: begin
                if (!rw) begin
                    state_nx = IDLE;
                end else if (cnt == 4'd0) begin
                    state_nx = ACCEPT;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            ACCEPT: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // waitrequest is flopped from the next state so it is low exactly while in ACCEPT.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            waitrequest <= 1'b1;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            waitrequest <= (state_nx != ACCEPT);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else if (commit_wr) begin
            bank[address] <= writedata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            readdatavalid <= 1'b0;
            readdata      <= '0;
            wr_count      <= '0;
            rd_count      <= '0;
        end else begin
            readdatavalid <= commit_rd;
            if (commit_rd) begin
                readdata <= bank[address];
                rd_count <= rd_count + CW'(1);
            end
            if (commit_wr) begin
                wr_count <= wr_count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_avalon_reg_slave.sv
// Bench for avalon_reg_slave: a master driver, a reference bank model and a
// readdatavalid-driven scoreboard; a second instance with CW = 2 checks counter wrap.
module tb_avalon_reg_slave;

    localparam int AW   = 4;
    localparam int DW   = 4;
    localparam int WAIT = 3;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          read;
    logic          write;
    logic [AW-1:0] address;
    logic [DW-1:0] writedata;
    logic          waitrequest;
    logic          readdatavalid;
    logic [DW-1:0] readdata;
    logic [7:0]    wr_count;
    logic [7:0]    rd_count;
    logic          waitrequest2;
    logic          readdatavalid2;
    logic [DW-1:0] readdata2;
    logic [1:0]    wr_count2;
    logic [1:0]    rd_count2;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int acc_cyc = 0;

    // reference model: bank contents, transaction totals, expected read data queue
    logic [DW-1:0] exp_bank [16];
    int            exp_wr;
    int            exp_rd;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_rd;

    avalon_reg_slave #(.AW(AW), .DW(DW), .WAIT(WAIT), .CW(8)) dut (
        .clock(clock), .reset_n(reset_n), .read(read), .write(write),
        .address(address), .writedata(writedata), .waitrequest(waitrequest),
        .readdatavalid(readdatavalid), .readdata(readdata),
        .wr_count(wr_count), .rd_count(rd_count)
    );

    avalon_reg_slave #(.AW(AW), .DW(DW), .WAIT(WAIT), .CW(2)) dut_cw2 (
        .clock(clock), .reset_n(reset_n), .read(read), .write(write),
        .address(address), .writedata(writedata), .waitrequest(waitrequest2),
        .readdatavalid(readdatavalid2), .readdata(readdata2),
        .wr_count(wr_count2), .rd_count(rd_count2)
    );

    // clock / reset block
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) exp_bank[i] = '0;
        exp_wr  = 0;
        exp_rd  = 0;
        exp_q.delete();
        last_rd = '0;
    endtask

    // scoreboard monitor: pops one expected value per readdatavalid pulse
    always @(negedge clock) begin
        if (reset_n) begin
            if (readdatavalid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_readdatavalid", 1, 0);
                end else begin
                    last_rd = exp_q.pop_front();
                    chk("readdata", readdata, last_rd);
                end
            end else begin
                chk("readdata_hold", readdata, last_rd);
            end
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        model_clear();
        repeat (2) @(negedge clock);
        chk("rst_waitrequest", waitrequest, 1);
        chk("rst_readdatavalid", readdatavalid, 0);
        chk("rst_readdata", readdata, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_rd_count", rd_count, 0);
        chk("rst_wr_count_cw2", wr_count2, 0);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    // reset asserted from a negedge in the middle of a transaction
    task automatic reset_now();
        reset_n = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        #1;
        chk("midrst_waitrequest", waitrequest, 1);
        chk("midrst_wr_count", wr_count, 0);
        model_clear();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        read  = 1'b0;
        write = 1'b0;
        repeat (n) begin
            @(negedge clock);
            chk("idle_waitrequest", waitrequest, 1);
        end
    endtask

    // driver: called at a negedge; leaves inputs asserted at the negedge after the commit
    task automatic issue(input logic rd, input logic wr, input logic [3:0] a, input logic [3:0] d);
        int n;
        read      = rd;
        write     = wr;
        address   = a;
        writedata = d;
        if (wr) begin
            exp_bank[a] = d;
            exp_wr++;
        end else if (rd) begin
            exp_q.push_back(exp_bank[a]);
            exp_rd++;
        end
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (waitrequest && n < 40);
        chk("accept_latency", n, WAIT + 1);
        acc_cyc = cyc;
        @(posedge clock);
        @(negedge clock);
        chk("waitrequest_after_accept", waitrequest, 1);
        chk("wr_count", wr_count, exp_wr % 256);
        chk("rd_count", rd_count, exp_rd % 256);
        chk("wr_count_cw2", wr_count2, exp_wr % 4);
        chk("rd_count_cw2", rd_count2, exp_rd % 4);
    endtask

    task automatic abort_txn(input logic [3:0] a, input logic [3:0] d);
        read      = 1'b0;
        write     = 1'b1;
        address   = a;
        writedata = d;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("abort_waitrequest", waitrequest, 1);
        idle(3);
        chk("abort_wr_count", wr_count, exp_wr % 256);
        chk("abort_rd_count", rd_count, exp_rd % 256);
    endtask

    initial begin
        int prev;
        int kind;
        reset_n   = 1'b0;
        read      = 1'b0;
        write     = 1'b0;
        address   = '0;
        writedata = '0;
        do_reset();

        // every address reads 0 after reset
        for (int i = 0; i < 16; i++) issue(1'b1, 1'b0, 4'(i), 4'd0);
        idle(2);

        // write 2 <- 5 then read it back from a fresh reset
        do_reset();
        issue(1'b0, 1'b1, 4'd2, 4'd5);
        issue(1'b1, 1'b0, 4'd2, 4'd0);
        idle(2);
        chk("wr_then_rd_wr_count", wr_count, 1);
        chk("wr_then_rd_rd_count", rd_count, 1);

        // back-to-back sweep, accepts spaced WAIT+2 cycles apart
        do_reset();
        prev = -1;
        for (int i = 0; i < 32; i++) begin
            if (i < 16) issue(1'b0, 1'b1, 4'(i), 4'(15 - i));
            else        issue(1'b1, 1'b0, 4'(i - 16), 4'd0);
            if (prev >= 0) chk("accept_spacing", acc_cyc - prev, WAIT + 2);
            prev = acc_cyc;
        end
        idle(2);
        chk("sweep_wr_count", wr_count, 16);
        chk("sweep_rd_count", rd_count, 16);

        // abort and read/write collision
        abort_txn(4'd4, 4'd1);
        issue(1'b1, 1'b0, 4'd4, 4'd0);
        issue(1'b1, 1'b1, 4'd3, 4'd9);
        idle(2);
        issue(1'b1, 1'b0, 4'd3, 4'd0);
        idle(2);

        // reset while WAITING on a write of 7 to address 1
        issue(1'b0, 1'b1, 4'd1, 4'd4);
        read      = 1'b0;
        write     = 1'b1;
        address   = 4'd1;
        writedata = 4'd7;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_now();
        issue(1'b1, 1'b0, 4'd1, 4'd0);
        idle(2);

        // reset in the accept cycle of a write
        issue(1'b0, 1'b1, 4'd1, 4'd4);
        read      = 1'b0;
        write     = 1'b1;
        address   = 4'd1;
        writedata = 4'd7;
        for (int n = 0; n < 40 && waitrequest; n++) @(negedge clock);
        chk("accept_reached", waitrequest, 0);
        reset_now();
        issue(1'b1, 1'b0, 4'd1, 4'd0);
        idle(2);

        // randomized traffic
        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 3)      issue(1'b0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            else if (kind <= 7) issue(1'b1, 1'b0, 4'($urandom_range(0, 15)), 4'd0);
            else if (kind == 8) issue(1'b1, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            else                abort_txn(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        idle(4);
        chk("pending_reads", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
